// File: rtl/sp_ram_master_pkg.sv
// rtl/sp_ram_master_pkg.sv - shared FSM state type and default widths for sp_ram_master
package sp_ram_master_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/sp_ram_rd_buf.sv
// rtl/sp_ram_rd_buf.sv - 2-entry synchronous FIFO holding read beats; push and pop may coincide
module sp_ram_rd_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [1:0]        count_o,
  output logic [DATA_W-1:0] head_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/sp_ram_master.sv
// rtl/sp_ram_master.sv - burst engine driving one single-port RAM; SP_RAM_MASTER_ERR_EN rejects
// bursts that would run past the top address instead of wrapping.
module sp_ram_master
  import sp_ram_master_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              done_o,
  output logic              err_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W:0]    remain_q, remain_d;
  logic              inflight_q;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              issue, wr_hs, pop, access, overflow;
  logic [1:0]        count;
  logic [2:0]        occ, lim;

`ifdef SP_RAM_MASTER_ERR_EN
  logic [ADDR_W+LEN_W:0] end_addr;
  assign end_addr = (ADDR_W+LEN_W+1)'(cmd_addr_i) + (ADDR_W+LEN_W+1)'(cmd_len_i);
  assign overflow = |end_addr[ADDR_W+LEN_W:ADDR_W];
`else
  assign overflow = 1'b0;
`endif

  assign pop = rd_valid_o & rd_ready_i;
  // Buffer slots already claimed: entries held plus the word still coming out of the RAM.
  assign occ = {1'b0, count} + {2'b00, inflight_q};
  assign lim = 3'd2 + {2'b00, pop};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    issue       = 1'b0;
    wr_hs       = 1'b0;
    cmd_ready_o = 1'b0;
    wr_ready_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          if (overflow) begin
            err_d = 1'b1;
          end else begin
            addr_d   = cmd_addr_i;
            remain_d = {1'b0, cmd_len_i} + (LEN_W+1)'(1);
            state_d  = cmd_write_i ? ST_WRITE : ST_READ;
          end
        end
      end
      ST_WRITE: begin
        wr_ready_o = 1'b1;
        if (wr_valid_i) begin
          wr_hs    = 1'b1;
          addr_d   = addr_q + ADDR_W'(1);
          remain_d = remain_q - (LEN_W+1)'(1);
          if (remain_q == (LEN_W+1)'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (occ < lim) begin
          issue    = 1'b1;
          addr_d   = addr_q + ADDR_W'(1);
          remain_d = remain_q - (LEN_W+1)'(1);
          if (remain_q == (LEN_W+1)'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!inflight_q && (count == 2'd0 || (count == 2'd1 && pop))) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      inflight_q <= issue;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  sp_ram_rd_buf #(
    .DATA_W(DATA_W)
  ) u_rd_buf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (inflight_q),
    .push_data_i(ram_rdata_i),
    .pop_i      (pop),
    .count_o    (count),
    .head_o     (rd_data_o)
  );

  // Reset kills any access in the same cycle so an aborted burst cannot touch the RAM.
  assign access      = (wr_hs | issue) & ~rst_i;
  assign ram_en_o    = access;
  assign ram_we_o    = wr_hs & ~rst_i;
  assign ram_addr_o  = access ? addr_q : '0;
  assign ram_wdata_o = (wr_hs & ~rst_i) ? wr_data_i : '0;
  assign rd_valid_o  = (count != 2'd0);
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_sp_ram_master.sv
// tb/tb_sp_ram_master.sv - directed self-checking bench for sp_ram_master with a behavioural RAM
module tb_sp_ram_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [4:0] cmd_addr, cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic       done, err;
  logic       ram_en, ram_we;
  logic [4:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata = 8'h00;

  logic [7:0] mem [32];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         en_cnt = 0;
  logic [4:0] waddr_q [$];
  logic [7:0] rdq [$];

  always #5 clk = ~clk;

  sp_ram_master dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
    .done_o(done), .err_o(err),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  always @(negedge clk) begin
    if (ram_en) begin
      en_cnt++;
      if (ram_we) waddr_q.push_back(ram_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [4:0] len, input logic [7:0] d0,
                          input bit gappy);
    int beat = 0;
    int n = 0;
    bit hs;
    en_cnt = 0;
    waddr_q.delete();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
    while (beat <= int'(len) && n < 64) begin
      wr_valid = gappy ? (n % 2 == 0) : 1'b1;
      wr_data  = d0 + 8'(beat);
      #1;
      hs = wr_valid && wr_ready;
      tick();
      if (hs) beat++;
      n++;
    end
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    check("wr_beats", beat, 32'(len) + 1);
    check("wr_done", done, 1);
    check("wr_done_cmd_ready", cmd_ready, 1);
    tick();
    check("wr_done_once", done, 0);
  endtask

  task automatic do_read(input logic [4:0] a, input logic [4:0] len, input int stall_after,
                         input int stall_len, output int lat, output int span, output int done_gap);
    int t0, first_rv = -1, pops = 0, stall = 0, n = 0, first_pop = 0, last_pop = 0, done_cyc = -1;
    bit stalling;
    en_cnt = 0;
    rdq.delete();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = len;
    #1;
    t0 = cyc;
    tick();
    cmd_valid = 1'b0;
    while (done_cyc < 0 && n < 200) begin
      stalling = (pops == stall_after) && (stall < stall_len);
      rd_ready = !stalling;
      #1;
      if (rd_valid && first_rv < 0) first_rv = cyc;
      if (stalling) begin
        stall++;
        if (stall == stall_len) begin
          check("stall_ram_en_off", ram_en, 0);
          check("stall_rd_valid", rd_valid, 1);
        end
      end
      if (rd_valid && rd_ready) begin
        rdq.push_back(rd_data);
        if (pops == 0) first_pop = cyc;
        last_pop = cyc;
        pops++;
      end
      tick();
      n++;
      if (done) done_cyc = cyc;
    end
    rd_ready = 1'b0;
    check("rd_done_seen", done_cyc >= 0, 1);
    check("rd_done_cmd_ready", cmd_ready, 1);
    tick();
    check("rd_done_once", done, 0);
    lat      = first_rv - t0;
    span     = last_pop - first_pop;
    done_gap = done_cyc - last_pop;
  endtask

  initial begin
    int lat, span, gap, n;
    bit saw_done;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    tick(); tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    tick();

    do_write(5'd3, 5'd3, 8'hA0, 1'b0);
    check("w3_en_cnt", en_cnt, 4);
    for (int i = 0; i < 4; i++) check("w3_addr", waddr_q.size() > i ? waddr_q[i] : 5'h1f, 3 + i);

    do_read(5'd3, 5'd3, -1, 0, lat, span, gap);
    check("r3_count", rdq.size(), 4);
    for (int i = 0; i < 4; i++) check("r3_data", rdq.size() > i ? rdq[i] : 8'hxx, 8'hA0 + i);
    check("r3_latency", lat, 3);
    check("r3_done_gap", gap, 1);
    check("r3_issues", en_cnt, 4);

    do_write(5'd8, 5'd7, 8'h10, 1'b0);
    do_read(5'd8, 5'd7, -1, 0, lat, span, gap);
    check("r8_count", rdq.size(), 8);
    check("r8_back_to_back", span, 7);
    check("r8_done_gap", gap, 1);
    check("r8_issues", en_cnt, 8);
    for (int i = 0; i < 8; i++) check("r8_data", rdq.size() > i ? rdq[i] : 8'hxx, 8'h10 + i);

    do_read(5'd8, 5'd7, 2, 5, lat, span, gap);
    check("rbp_count", rdq.size(), 8);
    check("rbp_issues", en_cnt, 8);
    for (int i = 0; i < 8; i++) check("rbp_data", rdq.size() > i ? rdq[i] : 8'hxx, 8'h10 + i);

`ifdef SP_RAM_MASTER_ERR_EN
    en_cnt = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd30; cmd_len = 5'd3;
    tick();
    cmd_valid = 1'b0;
    check("err_pulse", err, 1);
    check("err_cmd_ready", cmd_ready, 1);
    check("err_wr_ready", wr_ready, 0);
    tick();
    check("err_clear", err, 0);
    check("err_no_access", en_cnt, 0);
`else
    do_write(5'd30, 5'd3, 8'hD0, 1'b0);
    check("wrap_a0", waddr_q.size() > 0 ? waddr_q[0] : 5'h00, 30);
    check("wrap_a1", waddr_q.size() > 1 ? waddr_q[1] : 5'h00, 31);
    check("wrap_a2", waddr_q.size() > 2 ? waddr_q[2] : 5'h1f, 0);
    check("wrap_a3", waddr_q.size() > 3 ? waddr_q[3] : 5'h1f, 1);
    check("wrap_mem0", mem[0], 8'hD2);
    check("wrap_err", err, 0);
`endif

    do_write(5'd20, 5'd3, 8'hC0, 1'b1);
    check("gap_en_cnt", en_cnt, 4);
    for (int i = 0; i < 4; i++) check("gap_addr", waddr_q.size() > i ? waddr_q[i] : 5'h00, 20 + i);
    check("gap_mem23", mem[23], 8'hC3);

    en_cnt = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd8; cmd_len = 5'd7;
    tick();
    cmd_valid = 1'b0;
    rd_ready = 1'b1;
    n = 0;
    while (en_cnt < 2 && n < 20) begin
      tick();
      n++;
    end
    check("rstmid_beat3_en", ram_en, 1);
    rst = 1'b1;
    #1;
    check("rstmid_ram_en", ram_en, 0);
    tick();
    rst = 1'b0;
    rd_ready = 1'b0;
    #1;
    check("rstmid_rd_valid", rd_valid, 0);
    check("rstmid_cmd_ready", cmd_ready, 1);
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    check("rstmid_no_done", saw_done, 0);
    check("rstmid_idle_en", ram_en, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
